capture_readout: RTL

- Sits directly downstream of the oscilloscope acquisition core, in the main `clk` domain.
- Once a capture completes (`data_ready` high) and the host issues a read command, it walks the capture RAM starting at the first pre-trigger sample and fetches `nsmp` samples per enabled channel.
- It streams the bytes channel-by-channel to the host byte link over a valid/ready handshake.
- When finished it optionally pulses `start_trigger` to re-arm acquisition.

---
 rtl/capture_readout.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/capture_readout.sv
// Capture RAM readout: walks nsmp samples per enabled channel from the first
// pre-trigger address and streams them to the host byte link.
module capture_readout #(
    parameter int RAM_WIDTH = 10,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 read_go,
    input  logic                 rearm,
    input  logic [3:0]           chmask,
    input  logic                 data_ready,
    input  logic [RAM_WIDTH-1:0] trig_addr,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] nsmp,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [7:0]           ram_q1,
    input  logic [7:0]           ram_q2,
    input  logic [7:0]           ram_q3,
    input  logic [7:0]           ram_q4,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 read_done,
    output logic                 start_trigger,
    output logic                 ignored_cmd,
    output logic [2:0]           state_dbg
);

    // Byte link: a byte moves in every cycle where tx_valid && tx_ready are both
    // high at the rising clk edge; tx_data/tx_valid stay stable until then.
    typedef enum logic [2:0] {IDLE, SETUP, ADDR, WAIT, SEND, NEXT, DONE} state_t;

    state_t               state, state_next;
    logic [3:0]           mask_q;
    logic [RAM_WIDTH-1:0] nsmp_q;
    logic                 rearm_q;
    logic [RAM_WIDTH-1:0] base;
    logic [RAM_WIDTH-1:0] n;
    logic [1:0]           ch;
    logic [2:0]           wcnt;
    logic [2:0]           first_ch;
    logic [2:0]           next_ch;
    logic                 more;
    logic                 wait_last;
    logic [7:0]           ram_sel;

    // Lowest enabled channel at or above 'from'; bit 2 set means none left.
    function automatic logic [2:0] pick_ch(input logic [3:0] m, input logic [2:0] from);
        pick_ch = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) pick_ch = 3'(i);
        end
    endfunction

    assign first_ch  = pick_ch(chmask, 3'd0);
    assign next_ch   = pick_ch(mask_q, {1'b0, ch} + 3'd1);
    assign more      = ({1'b0, n} + 1'b1) < {1'b0, nsmp_q};
    assign wait_last = (wcnt == 3'(RD_LAT - 1));
    assign rdaddress = base + n;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        ram_sel = ram_q1;
        case (ch)
            2'd0:    ram_sel = ram_q1;
            2'd1:    ram_sel = ram_q2;
            2'd2:    ram_sel = ram_q3;
            default: ram_sel = ram_q4;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        rden          = 1'b0;
        read_done     = 1'b0;
        start_trigger = 1'b0;
        ignored_cmd   = 1'b0;
        case (state)
            IDLE: begin
                if (read_go) begin
                    if (data_ready) state_next = SETUP;
                    else            ignored_cmd = 1'b1;
                end
            end
            SETUP:   state_next = (mask_q == 4'd0 || nsmp_q == '0) ? DONE : ADDR;
            ADDR: begin
                rden       = 1'b1;
                state_next = WAIT;
            end
            WAIT:    if (wait_last) state_next = SEND;
            SEND:    if (tx_ready) state_next = NEXT;
            NEXT:    state_next = (more || !next_ch[2]) ? ADDR : DONE;
            DONE: begin
                read_done     = 1'b1;
                start_trigger = rearm_q;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q   <= '0;
            nsmp_q   <= '0;
            rearm_q  <= 1'b0;
            base     <= '0;
            n        <= '0;
            ch       <= '0;
            wcnt     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_go && data_ready) begin
                        mask_q  <= chmask;
                        nsmp_q  <= nsmp;
                        rearm_q <= rearm;
                        base    <= trig_addr - triggerpoint;
                        ch      <= first_ch[1:0];
                        n       <= '0;
                    end
                end
                ADDR: wcnt <= '0;
                // The RAM word requested in ADDR is on ram_q in the last WAIT cycle.
                WAIT: begin
                    if (wait_last) begin
                        tx_data  <= ram_sel;
                        tx_valid <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                SEND: if (tx_ready) tx_valid <= 1'b0;
                NEXT: begin
                    if (more) begin
                        n <= n + 1'b1;
                    end else if (!next_ch[2]) begin
                        ch <= next_ch[1:0];
                        n  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
